// File: rtl/multi_operand_accum_adder.sv
// rtl/multi_operand_accum_adder.sv - accumulates N_OPS operands per group and presents a registered sum
//
// Purpose: adds or subtracts a stream of N_OPS unsigned operands into an
// accumulator. The result is registered into z with a sticky carry/borrow
// flag, and it is held while downstream applies backpressure.
// Optional feature: define ACCUM_SATURATE_EN to clamp the accumulator
// (carry -> all-ones, borrow -> 0) instead of wrapping it.
//
// Ports:
//   clk       - single clock, rising edge
//   reset     - asynchronous active-high reset, clears all state
//   a         - unsigned operand
//   sub       - 1 = subtract a, 0 = add a (ignored on the first operand of a group)
//   in_valid  - operand valid
//   in_ready  - block can accept an operand (combinational from state)
//   flush     - synchronous abort of the current group
//   z         - registered group result
//   out_valid - z holds a completed group result
//   out_ready - downstream accepts z
//   ovf       - sticky carry/borrow of the group, valid with out_valid
//   op_count  - operands accepted in the current group
module multi_operand_accum_adder #(
  parameter int WIDTH = 8,
  parameter int N_OPS = 4,
  parameter int CNT_W = $clog2(N_OPS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // op_count value while the final operand of a group is being accepted.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_OPS - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;

  logic [WIDTH:0]   sum_ext;
  logic             carry;
  logic [WIDTH-1:0] next_acc;

  assign in_ready = (state != DONE);

  // Bit WIDTH of the extended result is the carry on add and the borrow on
  // subtract, because both operands are zero-extended.
  always_comb begin
    sum_ext  = '0;
    carry    = 1'b0;
    next_acc = '0;
    if (sub) begin
      sum_ext = {1'b0, acc} - {1'b0, a};
    end else begin
      sum_ext = {1'b0, acc} + {1'b0, a};
    end
    carry = sum_ext[WIDTH];
`ifdef ACCUM_SATURATE_EN
    if (carry) begin
      next_acc = sub ? '0 : '1;
    end else begin
      next_acc = sum_ext[WIDTH-1:0];
    end
`else
    next_acc = sum_ext[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      z         <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      op_count  <= '0;
    end else if (flush) begin
      // flush wins over any handshake in the same cycle; z keeps its last value.
      state     <= IDLE;
      acc       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc      <= a;
            ovf      <= 1'b0;
            op_count <= CNT_W'(1);
            if (N_OPS == 1) begin
              z         <= a;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc      <= next_acc;
            ovf      <= ovf | carry;
            op_count <= op_count + CNT_W'(1);
            if (op_count == LAST_CNT) begin
              // The result is registered on the edge that takes the last operand.
              z         <= next_acc;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            op_count  <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
